icmp_echo_rx: RTL and testbench

//  Upstream stage of the ping payload buffer. Parses 32-bit Rx frame words from the MAC and qualifies IPv4 ICMP echo requests addressed to us.

---
 rtl/icmp_echo_rx_pkg.sv | 38 +++
 rtl/icmp_echo_rx_if.sv | 10 +
 rtl/icmp_echo_rx_ip_hdr_csum.sv | 26 ++
 rtl/icmp_echo_rx.sv | 211 +++++++++++++++++++++
 tb/tb_icmp_echo_rx.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icmp_echo_rx_pkg.sv
// Shared constants, frame word indices and FSM encoding for the ICMP echo request receiver.
// Optional IP header checksum check is enabled by defining CHECK_IP_CSUM_EN.
package icmp_rx_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_ICMP  = 8'd1;
  localparam logic [7:0]  ICMP_ECHO_REQ  = 8'd8;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [15:0] IP_HDR_BYTES   = 16'd20;
  localparam logic [15:0] MIN_TOTAL_LEN  = 16'd28;

  // Word positions within a frame (2-byte pad precedes the destination MAC)
  localparam logic [3:0] W_SMAC_HI = 4'd2;
  localparam logic [3:0] W_ETYPE   = 4'd3;
  localparam logic [3:0] W_IPVER   = 4'd4;
  localparam logic [3:0] W_IPID    = 4'd5;
  localparam logic [3:0] W_PROTO   = 4'd6;
  localparam logic [3:0] W_SRCIP   = 4'd7;
  localparam logic [3:0] W_DSTIP   = 4'd8;
  localparam logic [3:0] W_ICMP    = 4'd9;

  typedef enum logic [2:0] {IDLE, HDR, FWD, DONE, SKIP} rx_state_e;

  // Ones-complement add with end-around carry; one fold suffices for two operands.
  function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Number of 32-bit words carrying the ICMP message for a given IP total length.
  function automatic logic [15:0] icmp_word_count(input logic [15:0] total_len);
    logic [15:0] b;
    b = total_len - IP_HDR_BYTES + 16'd3;
    return {2'b00, b[15:2]};
  endfunction

endpackage

// File: rtl/icmp_echo_rx_if.sv
// Rx frame word stream from the MAC: 32-bit big-endian words with valid/sop/eop framing.
interface icmp_echo_rx_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;

  modport master (output rx_data, rx_valid, rx_sop, rx_eop);
  modport slave  (input  rx_data, rx_valid, rx_sop, rx_eop);
endinterface

// File: rtl/icmp_echo_rx_ip_hdr_csum.sv
// 16-bit ones-complement accumulator over IPv4 header words; sum_o includes the word on data_i.
// Only built when CHECK_IP_CSUM_EN is defined.
`ifdef CHECK_IP_CSUM_EN
module ip_hdr_csum
  import icmp_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [31:0] data_i,
  output logic [15:0] sum_o
);

  logic [15:0] acc_q;

  assign sum_o = oc_add16(acc_q, oc_add16(data_i[31:16], data_i[15:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc_q <= 16'd0;
    else if (clr_i) acc_q <= 16'd0;
    else if (add_i) acc_q <= sum_o;
  end

endmodule
`endif

// File: rtl/icmp_echo_rx.sv
// Qualifies IPv4 ICMP echo requests for our address and streams the ICMP message to the payload buffer.
// Define CHECK_IP_CSUM_EN to also reject frames whose IP header checksum is wrong.
module icmp_echo_rx
  import icmp_rx_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int WCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         i_local_ip,
  icmp_echo_rx_if.slave       rx,
  input  logic                i_tx_busy,
  output logic                o_start,
  output logic                o_wren,
  output logic [31:0]         o_data,
  output logic                o_eop,
  output logic [47:0]         o_peer_mac,
  output logic [31:0]         o_peer_ip,
  output logic [15:0]         o_ip_id,
  output logic [15:0]         o_icmp_len,
  output logic                o_drop
);

  localparam logic [WCNT_W:0] MAX_CNT = (WCNT_W+1)'(MAX_WORDS);

  rx_state_e         state_q, state_d;
  logic [3:0]        w_q, w_d;
  logic [WCNT_W:0]   cnt_q, cnt_d;
  logic              eop_seen_q, eop_seen_d;
  logic              start_q, start_d;
  logic              wren_q, wren_d;
  logic [31:0]       data_q, data_d;
  logic              eop_q, eop_d;
  logic              drop_q, drop_d;
  logic [47:0]       peer_mac_q;
  logic [31:0]       peer_ip_q;
  logic [15:0]       ip_id_q;
  logic [15:0]       icmp_len_q;

  logic [47:0]       sh_mac_q;
  logic [31:0]       sh_ip_q;
  logic [15:0]       sh_id_q;
  logic [15:0]       len_q;

  logic              hdr_ok;
  logic              csum_ok;
  logic [15:0]       cnt_inc;
  logic [15:0]       need_words;

  assign cnt_inc    = 16'(cnt_q) + 16'd1;
  assign need_words = icmp_word_count(len_q);

`ifdef CHECK_IP_CSUM_EN
  logic [15:0] csum_sum;

  ip_hdr_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rx.rx_valid && rx.rx_sop),
    .add_i  (state_q == HDR && rx.rx_valid && w_q >= W_IPVER && w_q <= W_DSTIP),
    .data_i (rx.rx_data),
    .sum_o  (csum_sum)
  );

  assign csum_ok = (csum_sum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    eop_seen_d = eop_seen_q;
    start_d    = 1'b0;
    wren_d     = 1'b0;
    data_d     = data_q;
    eop_d      = 1'b0;
    drop_d     = 1'b0;
    hdr_ok     = 1'b1;

    if (rx.rx_valid && rx.rx_sop) begin
      // A new frame always wins; a completed message still gets its eop.
      state_d    = rx.rx_eop ? IDLE : HDR;
      w_d        = 4'd1;
      cnt_d      = '0;
      eop_seen_d = 1'b0;
      drop_d     = (state_q == FWD);
      eop_d      = (state_q == DONE);
    end else begin
      case (state_q)
        IDLE: ;
        HDR: begin
          if (rx.rx_valid) begin
            w_d = w_q + 4'd1;
            case (w_q)
              W_ETYPE: hdr_ok = (rx.rx_data[15:0] == ETHERTYPE_IPV4);
              W_IPVER: hdr_ok = (rx.rx_data[31:24] == IPV4_VER_IHL);
              W_PROTO: hdr_ok = (rx.rx_data[23:16] == IP_PROTO_ICMP);
              W_DSTIP: hdr_ok = (rx.rx_data == i_local_ip) && !i_tx_busy && csum_ok;
              W_ICMP:  hdr_ok = (rx.rx_data[31:24] == ICMP_ECHO_REQ) &&
                                (rx.rx_data[23:16] == 8'd0) &&
                                (len_q >= MIN_TOTAL_LEN) && !rx.rx_eop;
              default: ;
            endcase
            if (!hdr_ok) begin
              state_d = rx.rx_eop ? IDLE : SKIP;
            end else if (rx.rx_eop) begin
              state_d = IDLE;
            end else if (w_q == W_ICMP) begin
              state_d = FWD;
              start_d = 1'b1;
              wren_d  = 1'b1;
              data_d  = rx.rx_data;
              cnt_d   = {{WCNT_W{1'b0}}, 1'b1};
            end
          end
        end
        FWD: begin
          if (rx.rx_valid) begin
            if (cnt_q == MAX_CNT) begin
              drop_d  = 1'b1;
              state_d = rx.rx_eop ? IDLE : SKIP;
            end else if (cnt_inc == need_words) begin
              wren_d     = 1'b1;
              data_d     = rx.rx_data;
              cnt_d      = cnt_inc[WCNT_W:0];
              eop_seen_d = rx.rx_eop;
              state_d    = DONE;
            end else if (rx.rx_eop) begin
              drop_d  = 1'b1;
              state_d = IDLE;
            end else begin
              wren_d = 1'b1;
              data_d = rx.rx_data;
              cnt_d  = cnt_inc[WCNT_W:0];
            end
          end
        end
        DONE: begin
          eop_d   = 1'b1;
          state_d = (eop_seen_q || (rx.rx_valid && rx.rx_eop)) ? IDLE : SKIP;
        end
        SKIP: begin
          if (rx.rx_valid && rx.rx_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      w_q        <= 4'd0;
      cnt_q      <= '0;
      eop_seen_q <= 1'b0;
      start_q    <= 1'b0;
      wren_q     <= 1'b0;
      data_q     <= 32'd0;
      eop_q      <= 1'b0;
      drop_q     <= 1'b0;
      peer_mac_q <= 48'd0;
      peer_ip_q  <= 32'd0;
      ip_id_q    <= 16'd0;
      icmp_len_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      eop_seen_q <= eop_seen_d;
      start_q    <= start_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      eop_q      <= eop_d;
      drop_q     <= drop_d;
      // Peer fields only move on completion so the reply builder sees a stable set.
      if (eop_d) begin
        peer_mac_q <= sh_mac_q;
        peer_ip_q  <= sh_ip_q;
        ip_id_q    <= sh_id_q;
        icmp_len_q <= len_q - IP_HDR_BYTES;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == HDR && rx.rx_valid && !rx.rx_sop) begin
      case (w_q)
        W_SMAC_HI: sh_mac_q[47:16] <= rx.rx_data;
        W_ETYPE:   sh_mac_q[15:0]  <= rx.rx_data[31:16];
        W_IPVER:   len_q           <= rx.rx_data[15:0];
        W_IPID:    sh_id_q         <= rx.rx_data[31:16];
        W_SRCIP:   sh_ip_q         <= rx.rx_data;
        default: ;
      endcase
    end
  end

  assign o_start    = start_q;
  assign o_wren     = wren_q;
  assign o_data     = data_q;
  assign o_eop      = eop_q;
  assign o_drop     = drop_q;
  assign o_peer_mac = peer_mac_q;
  assign o_peer_ip  = peer_ip_q;
  assign o_ip_id    = ip_id_q;
  assign o_icmp_len = icmp_len_q;

endmodule

// File: tb/tb_icmp_echo_rx.sv
// Self-checking bench for icmp_echo_rx: table of frames plus reset and sop-restart sequences.
module tb_icmp_echo_rx;

  localparam logic [31:0] LIP  = 32'hC0A8_0105;
  localparam logic [47:0] DMAC = 48'h02AA_BBCC_DDEE;
`ifdef CHECK_IP_CSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif
  localparam int NVEC = 15;

  logic clk = 1'b0;
  logic rst;
  logic i_tx_busy;
  logic o_start, o_wren, o_eop, o_drop;
  logic [31:0] o_data, o_peer_ip;
  logic [47:0] o_peer_mac;
  logic [15:0] o_ip_id, o_icmp_len;

  always #5 clk = ~clk;

  icmp_echo_rx_if rx_if ();

  icmp_echo_rx dut (
    .clk        (clk),
    .rst        (rst),
    .i_local_ip (LIP),
    .rx         (rx_if),
    .i_tx_busy  (i_tx_busy),
    .o_start    (o_start),
    .o_wren     (o_wren),
    .o_data     (o_data),
    .o_eop      (o_eop),
    .o_peer_mac (o_peer_mac),
    .o_peer_ip  (o_peer_ip),
    .o_ip_id    (o_ip_id),
    .o_icmp_len (o_icmp_len),
    .o_drop     (o_drop)
  );

  typedef struct {
    logic [31:0] dst_ip;
    logic [15:0] tl;
    logic [7:0]  proto;
    logic [15:0] etype;
    logic [7:0]  itype;
    logic [7:0]  icode;
    bit          busy;
    bit          bad_cs;
    int          eop_at;
    int          exp_wren;
    bit          exp_eop;
    bit          exp_drop;
  } vec_t;

  typedef struct packed {
    logic        start;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [15:0] len;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] id;
  } meta_t;

  vec_t        vecs [NVEC];
  wr_t         exp_wr [$];
  meta_t       exp_meta [$];
  logic [31:0] fw [$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_wren  = 0;
  int n_eop   = 0;
  int n_drop  = 0;
  int cyc     = 0;
  int last_wren_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] dip, logic [15:0] tl, logic [7:0] proto,
                              logic [15:0] et, logic [7:0] ty, logic [7:0] cd, bit busy,
                              bit badcs, int eop_at, int ew, bit ee, bit ed);
    vec_t v;
    v.dst_ip = dip; v.tl = tl; v.proto = proto; v.etype = et; v.itype = ty; v.icode = cd;
    v.busy = busy; v.bad_cs = badcs; v.eop_at = eop_at;
    v.exp_wren = ew; v.exp_eop = ee; v.exp_drop = ed;
    return v;
  endfunction

  // Scoreboard consumer: every DUT write/eop is matched against the expected queues.
  always @(posedge clk) begin
    wr_t   e;
    meta_t m;
    #1;
    cyc++;
    if (o_wren) begin
      n_wren++;
      last_wren_cyc = cyc;
      if (exp_wr.size() == 0) begin
        check("unexpected_wren", {32'd0, o_data}, 64'hDEAD_0000_0000_0000);
      end else begin
        e = exp_wr.pop_front();
        check("wren_data", {32'd0, o_data}, {32'd0, e.data});
        check("wren_start", {63'd0, o_start}, {63'd0, e.start});
      end
    end
    if (o_eop) begin
      n_eop++;
      check("eop_after_last_wren", 64'(cyc - last_wren_cyc), 64'd1);
      if (exp_meta.size() == 0) begin
        check("unexpected_eop", 64'd1, 64'd0);
      end else begin
        m = exp_meta.pop_front();
        check("icmp_len", {48'd0, o_icmp_len}, {48'd0, m.len});
        check("peer_mac", {16'd0, o_peer_mac}, {16'd0, m.mac});
        check("peer_ip", {32'd0, o_peer_ip}, {32'd0, m.ip});
        check("ip_id", {48'd0, o_ip_id}, {48'd0, m.id});
      end
    end
    if (o_drop) n_drop++;
  end

  task automatic build(input vec_t v, input logic [47:0] mac, input logic [31:0] pip,
                       input logic [15:0] id);
    logic [31:0] h [5];
    logic [31:0] s;
    logic [15:0] cs;
    int need;
    fw.delete();
    h[0] = {8'h45, 8'h00, v.tl};
    h[1] = {id, 16'h4000};
    h[2] = {8'h40, v.proto, 16'h0000};
    h[3] = pip;
    h[4] = v.dst_ip;
    s = 32'd0;
    for (int k = 0; k < 5; k++) s = s + {16'd0, h[k][31:16]} + {16'd0, h[k][15:0]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    if (v.bad_cs) cs = cs ^ 16'h0001;
    h[2][15:0] = cs;
    fw.push_back({16'h0000, DMAC[47:32]});
    fw.push_back(DMAC[31:0]);
    fw.push_back(mac[47:16]);
    fw.push_back({mac[15:0], v.etype});
    for (int k = 0; k < 5; k++) fw.push_back(h[k]);
    fw.push_back({v.itype, v.icode, 16'hBEEF});
    need = (v.tl >= 16'd28) ? (int'(v.tl) - 20 + 3) / 4 : 2;
    for (int k = 1; k < need; k++) fw.push_back($urandom);
    fw.push_back($urandom);
    if (v.eop_at > 0) while (fw.size() > v.eop_at + 1) fw.delete(fw.size() - 1);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_wr.push_back({(i == 0), fw[9 + i]});
  endtask

  task automatic send(input int first, input int n, input bit with_eop);
    for (int i = first; i < first + n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx_if.rx_valid = 1'b0;
        @(negedge clk);
      end
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data  = fw[i];
      rx_if.rx_sop   = (i == 0);
      rx_if.rx_eop   = with_eop && (i == first + n - 1);
      @(negedge clk);
    end
    rx_if.rx_valid = 1'b0;
    rx_if.rx_sop   = 1'b0;
    rx_if.rx_eop   = 1'b0;
  endtask

  task automatic frame_checks(input string tag, input int ew, input int ee, input int ed);
    repeat (6) @(negedge clk);
    check({tag, " wren_count"}, 64'(n_wren), 64'(ew));
    check({tag, " eop_count"}, 64'(n_eop), 64'(ee));
    check({tag, " drop_count"}, 64'(n_drop), 64'(ed));
    check({tag, " pending_writes"}, 64'(exp_wr.size()), 64'd0);
    exp_wr.delete();
    exp_meta.delete();
    n_wren = 0;
    n_eop  = 0;
    n_drop = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " o_start"}, {63'd0, o_start}, 64'd0);
    check({tag, " o_wren"}, {63'd0, o_wren}, 64'd0);
    check({tag, " o_data"}, {32'd0, o_data}, 64'd0);
    check({tag, " o_eop"}, {63'd0, o_eop}, 64'd0);
    check({tag, " o_drop"}, {63'd0, o_drop}, 64'd0);
    check({tag, " o_peer_mac"}, {16'd0, o_peer_mac}, 64'd0);
    check({tag, " o_peer_ip"}, {32'd0, o_peer_ip}, 64'd0);
    check({tag, " o_ip_id"}, {48'd0, o_ip_id}, 64'd0);
    check({tag, " o_icmp_len"}, {48'd0, o_icmp_len}, 64'd0);
  endtask

  initial begin
    logic [47:0] mac;
    logic [31:0] pip;
    logic [15:0] id;

    vecs[0]  = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  16,  1, 0);
    vecs[1]  = mk(LIP ^ 32'h1,  16'd84,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  0,   0, 0);
    vecs[2]  = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd0, 8'd0, 0, 0, 0,  0,   0, 0);
    vecs[3]  = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  16,  1, 0);
    vecs[4]  = mk(LIP,          16'd1104, 8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  256, 0, 1);
    vecs[5]  = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 12, 3,   0, 1);
    vecs[6]  = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd8, 8'd0, 1, 0, 0,  0,   0, 0);
    vecs[7]  = mk(LIP,          16'd84,   8'd1, 16'h86DD, 8'd8, 8'd0, 0, 0, 0,  0,   0, 0);
    vecs[8]  = mk(LIP,          16'd28,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  2,   1, 0);
    vecs[9]  = mk(LIP,          16'd27,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  0,   0, 0);
    vecs[10] = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 1, 0,
                  CS_ON ? 0 : 16, !CS_ON, 0);
    vecs[11] = mk(LIP,          16'd84,   8'd1, 16'h0800, 8'd8, 8'd1, 0, 0, 0,  0,   0, 0);
    vecs[12] = mk(LIP,          16'd87,   8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  17,  1, 0);
    vecs[13] = mk(LIP,          16'd84,   8'd6, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  0,   0, 0);
    vecs[14] = mk(LIP,          16'd1044, 8'd1, 16'h0800, 8'd8, 8'd0, 0, 0, 0,  256, 1, 0);

    rst            = 1'b1;
    i_tx_busy      = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_sop   = 1'b0;
    rx_if.rx_eop   = 1'b0;
    rx_if.rx_data  = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      mac = {16'h0011, $urandom};
      pip = 32'hC0A8_0100 | 32'($urandom_range(2, 250));
      id  = 16'($urandom);
      build(vecs[i], mac, pip, id);
      push_words(vecs[i].exp_wren);
      if (vecs[i].exp_eop) exp_meta.push_back({vecs[i].tl - 16'd20, mac, pip, id});
      i_tx_busy = vecs[i].busy;
      send(0, fw.size(), 1'b1);
      i_tx_busy = 1'b0;
      frame_checks($sformatf("vec%0d", i), vecs[i].exp_wren, int'(vecs[i].exp_eop),
                   int'(vecs[i].exp_drop));
    end

    // Reset in the middle of forwarding: frame discarded, outputs cleared.
    build(vecs[0], 48'h0011_5566_7788, 32'hC0A8_0177, 16'h1234);
    push_words(3);
    send(0, 12, 1'b0);
    rst = 1'b1;
    #6;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(12, fw.size() - 12, 1'b1);
    frame_checks("midrst", 3, 0, 0);

    // New sop while forwarding abandons the old message and accepts the new one.
    build(vecs[0], 48'h0011_0000_0001, 32'hC0A8_0111, 16'hAAAA);
    push_words(4);
    send(0, 13, 1'b0);
    build(vecs[0], 48'h0011_0000_0002, 32'hC0A8_0122, 16'h5555);
    push_words(16);
    exp_meta.push_back({16'd64, 48'h0011_0000_0002, 32'hC0A8_0122, 16'h5555});
    send(0, fw.size(), 1'b1);
    frame_checks("restart", 20, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
